shift_req_queue: RTL

SHIFT_REQ_QUEUE -- requirements
Module: shift_req_queue

---
 rtl/shift_req_queue.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_req_queue.sv
// Request FIFO feeding an external combinational barrel shifter, with a single
// registered result stage and valid/ready handshakes on both sides.
module shift_req_queue #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_WIDTH-1:0]  in_data,
  input  logic [SHAMT_WIDTH-1:0]    in_shamt,
  input  logic [NUM_OPERATIONS-1:0] in_oper,
  output logic [OPERAND_WIDTH-1:0]  sh_in,
  output logic [SHAMT_WIDTH-1:0]    sh_shamt,
  output logic [NUM_OPERATIONS-1:0] sh_oper,
  input  logic [OPERAND_WIDTH-1:0]  sh_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  out_data,
  output logic [NUM_OPERATIONS-1:0] out_oper,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = OPERAND_WIDTH + SHAMT_WIDTH + NUM_OPERATIONS;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          empty;
  logic          push;
  logic          capture;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign capture  = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  // Downstream shifter sees zeros whenever the queue is empty.
  always_comb begin
    sh_in    = '0;
    sh_shamt = '0;
    sh_oper  = '0;
    if (!empty) begin
      {sh_in, sh_shamt, sh_oper} = head;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data, in_shamt, in_oper};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (capture) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, capture})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_oper  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= sh_out;
      out_oper  <= sh_oper;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
